irq_encoder16: RTL and testbench

- 16-source interrupt request encoder. It is the encode-side counterpart of the 4-to-16 one-hot decoder used for device select.
- Rising edges on 16 request lines are captured into pending bits and qualified by a software-writable mask.
- The highest-priority pending source (lowest index) is encoded to a 4-bit vector, presented to the CPU interrupt logic with a valid/ack handshake.
- Sits between peripheral IRQ wires and the CPU trap logic. The CPU acks each vector once it has been taken.

---
 rtl/irq_encoder16_if.sv | 22 ++
 rtl/irq_encoder16.sv | 79 +++++++
 tb/tb_irq_encoder16.sv | 173 +++++++++++++++++
 3 files changed

// File: rtl/irq_encoder16_if.sv
// Bus between the 16-source interrupt encoder and its host.
// The host drives requests, mask writes and ack. The encoder returns the vector and its status.
interface irq_encoder16_if;
    logic [15:0] irq_in;
    logic        mask_we;
    logic [15:0] mask_wdata;
    logic        ack;
    logic        valid;
    logic [3:0]  vec;
    logic [15:0] pending;
    logic [15:0] mask;

    modport master (
        output irq_in, mask_we, mask_wdata, ack,
        input  valid, vec, pending, mask
    );

    modport slave (
        input  irq_in, mask_we, mask_wdata, ack,
        output valid, vec, pending, mask
    );
endinterface

// File: rtl/irq_encoder16.sv
// 16-source interrupt encoder. It captures rising edges into pending bits, masks them,
// and presents the lowest pending index to the CPU with a valid/ack handshake.
module irq_encoder16 #(
    parameter logic [15:0] DEFAULT_MASK = 16'hFFFF
) (
    input  logic           clk,
    input  logic           rst,
    irq_encoder16_if.slave bus
);

    typedef enum logic {IDLE, PRESENT} state_t;

    state_t      state, state_next;
    logic [15:0] irq_prev;
    logic [15:0] pending_q;
    logic [15:0] mask_q;
    logic [3:0]  vec_q;

    logic [15:0] edges;
    logic [15:0] eligible;
    logic [15:0] clear;
    logic        vec_load;
    logic        ack_clear;

    function automatic logic [3:0] lowest_set(input logic [15:0] v);
        lowest_set = 4'h0;
        for (int i = 15; i >= 0; i--)
            if (v[i]) lowest_set = 4'(i);
    endfunction

    assign edges    = bus.irq_in & ~irq_prev;
    assign eligible = pending_q & mask_q;
    assign clear    = ack_clear ? (16'h0001 << vec_q) : 16'h0000;

    // NOTE: every signal written here gets a default first, so no path can infer a latch.
    always_comb begin
        state_next = state;
        vec_load   = 1'b0;
        ack_clear  = 1'b0;
        unique case (state)
            IDLE: begin
                if (|eligible) begin
                    state_next = PRESENT;
                    vec_load   = 1'b1;
                end
            end
            PRESENT: begin
                if (bus.ack) begin
                    state_next = IDLE;
                    ack_clear  = 1'b1;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments only, so every register sees pre-edge values.
    always_ff @(posedge clk) begin
        irq_prev <= bus.irq_in;
        if (rst) begin
            state     <= IDLE;
            pending_q <= 16'h0000;
            mask_q    <= DEFAULT_MASK;
            vec_q     <= 4'h0;
        end else begin
            state <= state_next;
            // If a new edge and an ack hit the same bit together, the set wins so the request is not lost.
            pending_q <= (pending_q & ~clear) | edges;
            if (bus.mask_we) mask_q <= bus.mask_wdata;
            if (vec_load)    vec_q  <= lowest_set(eligible);
        end
    end

    assign bus.valid   = (state == PRESENT);
    assign bus.vec     = vec_q;
    assign bus.pending = pending_q;
    assign bus.mask    = mask_q;

endmodule

// File: tb/tb_irq_encoder16.sv
// Directed bench for irq_encoder16. A table of per-cycle vectors is followed by
// hand-written reset sequences.
module tb_irq_encoder16;

    logic clk = 1'b0;
    logic rst;
    irq_encoder16_if bus ();

    irq_encoder16 #(.DEFAULT_MASK(16'hFFFF)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] irq;
        logic        mask_we;
        logic [15:0] mask_wdata;
        logic        ack;
        logic        exp_valid;
        logic [3:0]  exp_vec;
        logic [15:0] exp_pending;
        logic [15:0] exp_mask;
    } vec_t;

    vec_t vecs[$];
    int   tests  = 0;
    int   failed = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            failed++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic add(input logic [15:0] irq, input logic we, input logic [15:0] wd, input logic ack,
                       input logic v, input logic [3:0] vc, input logic [15:0] p, input logic [15:0] m);
        vec_t r;
        r.irq = irq; r.mask_we = we; r.mask_wdata = wd; r.ack = ack;
        r.exp_valid = v; r.exp_vec = vc; r.exp_pending = p; r.exp_mask = m;
        vecs.push_back(r);
    endtask

    task automatic drive(input logic [15:0] irq, input logic we, input logic [15:0] wd, input logic ack);
        bus.irq_in = irq; bus.mask_we = we; bus.mask_wdata = wd; bus.ack = ack;
    endtask

    task automatic check_all(input string tag, input logic v, input logic [3:0] vc,
                             input logic [15:0] p, input logic [15:0] m);
        check({tag, ".valid"},   32'(bus.valid),   32'(v));
        check({tag, ".vec"},     32'(bus.vec),     32'(vc));
        check({tag, ".pending"}, 32'(bus.pending), 32'(p));
        check({tag, ".mask"},    32'(bus.mask),    32'(m));
    endtask

    initial begin
        // Fields: irq, mask_we, mask_wdata, ack -> valid, vec, pending, mask.
        // Single pulse on bit 9.
        add(16'h0200, 0, 16'h0, 0,  0, 4'd0,  16'h0200, 16'hFFFF);
        add(16'h0000, 0, 16'h0, 0,  1, 4'd9,  16'h0200, 16'hFFFF);
        add(16'h0000, 0, 16'h0, 1,  0, 4'd9,  16'h0000, 16'hFFFF);
        add(16'h0000, 0, 16'h0, 0,  0, 4'd9,  16'h0000, 16'hFFFF);
        // Simultaneous bits 3, 7, 12.
        add(16'h1088, 0, 16'h0, 0,  0, 4'd9,  16'h1088, 16'hFFFF);
        add(16'h0000, 0, 16'h0, 0,  1, 4'd3,  16'h1088, 16'hFFFF);
        add(16'h0000, 0, 16'h0, 1,  0, 4'd3,  16'h1080, 16'hFFFF);
        add(16'h0000, 0, 16'h0, 0,  1, 4'd7,  16'h1080, 16'hFFFF);
        add(16'h0000, 0, 16'h0, 1,  0, 4'd7,  16'h1000, 16'hFFFF);
        add(16'h0000, 0, 16'h0, 0,  1, 4'd12, 16'h1000, 16'hFFFF);
        add(16'h0000, 0, 16'h0, 1,  0, 4'd12, 16'h0000, 16'hFFFF);
        add(16'h0000, 0, 16'h0, 0,  0, 4'd12, 16'h0000, 16'hFFFF);
        // Masked source accumulates and then becomes eligible when unmasked.
        add(16'h0000, 1, 16'hFFF7, 0, 0, 4'd12, 16'h0000, 16'hFFF7);
        add(16'h0008, 0, 16'h0, 0,  0, 4'd12, 16'h0008, 16'hFFF7);
        add(16'h0000, 0, 16'h0, 0,  0, 4'd12, 16'h0008, 16'hFFF7);
        add(16'h0000, 0, 16'h0, 0,  0, 4'd12, 16'h0008, 16'hFFF7);
        add(16'h0000, 1, 16'hFFFF, 0, 0, 4'd12, 16'h0008, 16'hFFFF);
        add(16'h0000, 0, 16'h0, 0,  1, 4'd3,  16'h0008, 16'hFFFF);
        add(16'h0000, 0, 16'h0, 1,  0, 4'd3,  16'h0000, 16'hFFFF);
        // Presented vector 5 is held while a higher-priority bit 1 arrives.
        add(16'h0020, 0, 16'h0, 0,  0, 4'd3,  16'h0020, 16'hFFFF);
        add(16'h0000, 0, 16'h0, 0,  1, 4'd5,  16'h0020, 16'hFFFF);
        add(16'h0002, 0, 16'h0, 0,  1, 4'd5,  16'h0022, 16'hFFFF);
        add(16'h0000, 0, 16'h0, 0,  1, 4'd5,  16'h0022, 16'hFFFF);
        add(16'h0000, 0, 16'h0, 1,  0, 4'd5,  16'h0002, 16'hFFFF);
        add(16'h0000, 0, 16'h0, 0,  1, 4'd1,  16'h0002, 16'hFFFF);
        add(16'h0000, 0, 16'h0, 1,  0, 4'd1,  16'h0000, 16'hFFFF);
        // A new edge on bit 5 together with its ack: the set wins and 5 is re-presented.
        add(16'h0020, 0, 16'h0, 0,  0, 4'd1,  16'h0020, 16'hFFFF);
        add(16'h0000, 0, 16'h0, 0,  1, 4'd5,  16'h0020, 16'hFFFF);
        add(16'h0020, 0, 16'h0, 1,  0, 4'd5,  16'h0020, 16'hFFFF);
        add(16'h0020, 0, 16'h0, 0,  1, 4'd5,  16'h0020, 16'hFFFF);
        add(16'h0000, 0, 16'h0, 1,  0, 4'd5,  16'h0000, 16'hFFFF);
        // The source is masked while presented: it is still delivered and cleared by ack.
        add(16'h0040, 0, 16'h0, 0,  0, 4'd5,  16'h0040, 16'hFFFF);
        add(16'h0000, 0, 16'h0, 0,  1, 4'd6,  16'h0040, 16'hFFFF);
        add(16'h0000, 1, 16'h0000, 0, 1, 4'd6, 16'h0040, 16'h0000);
        add(16'h0000, 0, 16'h0, 1,  0, 4'd6,  16'h0000, 16'h0000);
        add(16'h0000, 1, 16'hFFFF, 0, 0, 4'd6, 16'h0000, 16'hFFFF);

        // Reset with all lines low.
        rst = 1'b1;
        drive(16'h0000, 0, 16'h0, 0);
        step();
        step();
        rst = 1'b0;
        check_all("reset", 0, 4'd0, 16'h0000, 16'hFFFF);

        for (int i = 0; i < vecs.size(); i++) begin
            drive(vecs[i].irq, vecs[i].mask_we, vecs[i].mask_wdata, vecs[i].ack);
            step();
            check_all($sformatf("row%0d", i), vecs[i].exp_valid, vecs[i].exp_vec,
                      vecs[i].exp_pending, vecs[i].exp_mask);
        end

        // Reset while a vector is presented aborts it, and a later ack does nothing.
        drive(16'h0000, 1, 16'h7FFF, 0);
        step();
        drive(16'h0004, 0, 16'h0, 0);
        step();
        drive(16'h0000, 0, 16'h0, 0);
        step();
        check_all("abort.pre", 1, 4'd2, 16'h0004, 16'h7FFF);
        rst = 1'b1;
        step();
        rst = 1'b0;
        check_all("abort.rst", 0, 4'd0, 16'h0000, 16'hFFFF);
        drive(16'h0000, 0, 16'h0, 1);
        step();
        drive(16'h0000, 0, 16'h0, 0);
        check_all("abort.ack", 0, 4'd0, 16'h0000, 16'hFFFF);
        step();
        check_all("abort.idle", 0, 4'd0, 16'h0000, 16'hFFFF);

        // A line held high through reset release produces no request until it re-rises.
        drive(16'h0010, 0, 16'h0, 0);
        rst = 1'b1;
        step();
        rst = 1'b0;
        for (int i = 0; i < 10; i++) begin
            step();
            check($sformatf("held%0d.pending", i), 32'(bus.pending), 32'h0);
            check($sformatf("held%0d.valid", i),   32'(bus.valid),   32'h0);
        end
        drive(16'h0000, 0, 16'h0, 0);
        step();
        check("drop.pending", 32'(bus.pending), 32'h0);
        drive(16'h0010, 0, 16'h0, 0);
        step();
        check_all("rerise", 0, 4'd0, 16'h0010, 16'hFFFF);
        step();
        check_all("rerise.present", 1, 4'd4, 16'h0010, 16'hFFFF);
        drive(16'h0010, 0, 16'h0, 1);
        step();
        drive(16'h0010, 0, 16'h0, 0);
        check_all("rerise.ack", 0, 4'd4, 16'h0000, 16'hFFFF);
        step();
        check_all("rerise.quiet", 0, 4'd4, 16'h0000, 16'hFFFF);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
